// File: rtl/game_io_pkg.sv
// Purpose : shared address map defaults, peripheral indices and map helpers for game_io_bridge.
// Latency : n/a (package only).
// Backpr. : n/a.
package game_io_pkg;

  // Default port_id map
  localparam logic [7:0] OUT_BASE_DFLT      = 8'h02;
  localparam logic [7:0] IN_BASE_DFLT       = 8'h20;
  localparam logic [7:0] IRQ_STAT_ADDR_DFLT = 8'h30;
  localparam logic [7:0] IRQ_MASK_ADDR_DFLT = 8'h31;

  // Output register indices
  localparam int OUT_LED    = 0;
  localparam int OUT_DIG3   = 1;
  localparam int OUT_DIG2   = 2;
  localparam int OUT_DIG1   = 3;
  localparam int OUT_DIG0   = 4;
  localparam int OUT_DP     = 5;
  localparam int OUT_MOTCTL = 7;

  // Input channel indices
  localparam int IN_BTNS    = 0;
  localparam int IN_SW      = 1;
  localparam int IN_LOCX    = 2;
  localparam int IN_LOCY    = 3;
  localparam int IN_BOTINFO = 4;
  localparam int IN_SENSORS = 5;
  localparam int IN_LMDIST  = 6;
  localparam int IN_RMDIST  = 7;

  // Interrupt source indices
  localparam int IRQ_UPD_SYSREGS = 0;
  localparam int IRQ_MSEC_TICK   = 1;

  // True when [a_base, a_base+a_len) and [b_base, b_base+b_len) intersect.
  function automatic bit ranges_overlap(input int a_base, input int a_len,
                                        input int b_base, input int b_len);
    return (a_base < b_base + b_len) && (b_base < a_base + a_len);
  endfunction

endpackage

// File: rtl/game_io_bridge_irq_ctrl.sv
// Purpose : maskable rising-edge interrupt controller with KCPSM6 interrupt/ack handshake.
// Latency : source edge -> pending 1 clk, pending&mask -> interrupt 1 clk; ack drops interrupt next clk.
// Backpr. : none; events are latched in pending until cleared by write-1-to-clear.
// Ports   : clk, reset, irq_src, clr (W1C bits), mask_we/mask_din, ack -> pending, mask, interrupt.
module irq_ctrl
  import game_io_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [N_IRQ-1:0] clr,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_din,
  input  logic             ack,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             interrupt
);

  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ-1:0] rise;

  // src_q resets to 0, so a source already high at reset release counts as an edge.
  assign rise = irq_src & ~src_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      pending   <= '0;
      mask      <= '0;
      interrupt <= 1'b0;
    end else begin
      src_q   <= irq_src;
      // Set beats clear on the same bit so a coincident edge is never lost.
      pending <= (pending & ~clr) | rise;
      if (mask_we) begin
        mask <= mask_din;
      end
      // Ack wins for one cycle; the request is re-evaluated on the next.
      if (ack) begin
        interrupt <= 1'b0;
      end else begin
        interrupt <= |(pending & mask);
      end
    end
  end

endmodule

// File: rtl/game_io_bridge.sv
// Purpose : KCPSM6 port-mapped I/O bridge: output register bank, input read mux, interrupt controller.
// Latency : writes land on the strobe edge; in_port registered 1 clk after port_id.
// Backpr. : none; unmapped accesses are silently ignored and read as 8'h00.
// Ports   : KCPSM6 bus (port_id, out_port, strobes, in_port, interrupt, interrupt_ack),
//           in_regs (N_IN bytes), irq_src (N_IRQ), out_regs (N_OUT bytes).
module game_io_bridge
  import game_io_pkg::*;
#(
  parameter int         N_OUT         = 8,
  parameter int         N_IN          = 8,
  parameter int         N_IRQ         = 4,
  parameter logic [7:0] OUT_BASE      = OUT_BASE_DFLT,
  parameter logic [7:0] IN_BASE       = IN_BASE_DFLT,
  parameter logic [7:0] IRQ_STAT_ADDR = IRQ_STAT_ADDR_DFLT,
  parameter logic [7:0] IRQ_MASK_ADDR = IRQ_MASK_ADDR_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               k_write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         in_port,
  output logic               interrupt,
  input  logic               interrupt_ack,
  input  logic [N_IN*8-1:0]  in_regs,
  input  logic [N_IRQ-1:0]   irq_src,
  output logic [N_OUT*8-1:0] out_regs
);

  localparam int OB = int'(OUT_BASE);
  localparam int IB = int'(IN_BASE);
  localparam int SA = int'(IRQ_STAT_ADDR);
  localparam int MA = int'(IRQ_MASK_ADDR);

  // Elaboration-time sanity of the address map.
  if (N_OUT < 1 || N_OUT > 16 || N_IN < 1 || N_IN > 16 || N_IRQ < 1 || N_IRQ > 8) begin : g_size_error
    $error("game_io_bridge: N_OUT/N_IN must be 1..16 and N_IRQ 1..8");
  end
  if (ranges_overlap(OB, N_OUT, IB, N_IN) || ranges_overlap(OB, N_OUT, SA, 1) ||
      ranges_overlap(OB, N_OUT, MA, 1)    || ranges_overlap(IB, N_IN, SA, 1)   ||
      ranges_overlap(IB, N_IN, MA, 1)     || (SA == MA) ||
      (OB + N_OUT > 256) || (IB + N_IN > 256)) begin : g_map_error
    $error("game_io_bridge: address ranges overlap or exceed 8'hFF");
  end

  // read_strobe has no side effects; it is only carried for bus monitoring.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  // ---------------- write decode ----------------
  logic [7:0] wr_off;
  logic [7:0] k_addr;
  logic [7:0] k_off;
  logic       out_we;
  logic [7:0] out_we_off;

  // Offsets wrap modulo 256, so anything below the base lands far out of range.
  assign wr_off = port_id - OUT_BASE;
  assign k_addr = {OUT_BASE[7:4], port_id[3:0]};
  assign k_off  = k_addr - OUT_BASE;

  always_comb begin
    out_we     = 1'b0;
    out_we_off = wr_off;
    if (write_strobe) begin
      out_we = (wr_off < 8'(N_OUT));
    end else if (k_write_strobe) begin
      out_we     = (k_off < 8'(N_OUT));
      out_we_off = k_off;
    end
  end

  // ---------------- output bank ----------------
  logic [7:0] out_q [N_OUT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) begin
        out_q[i] <= 8'h00;
      end
    end else if (out_we) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (out_we_off == 8'(i)) begin
          out_q[i] <= out_port;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    assign out_regs[8*gi +: 8] = out_q[gi];
  end

  // ---------------- interrupt controller ----------------
  logic             stat_we;
  logic             mask_we;
  logic [N_IRQ-1:0] irq_clr;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;

  assign stat_we = write_strobe && (port_id == IRQ_STAT_ADDR);
  assign mask_we = write_strobe && (port_id == IRQ_MASK_ADDR);
  assign irq_clr = stat_we ? out_port[N_IRQ-1:0] : '0;

  irq_ctrl #(.N_IRQ(N_IRQ)) u_irq_ctrl (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .clr       (irq_clr),
    .mask_we   (mask_we),
    .mask_din  (out_port[N_IRQ-1:0]),
    .ack       (interrupt_ack),
    .pending   (pending),
    .mask      (mask),
    .interrupt (interrupt)
  );

  // ---------------- read mux ----------------
  logic [7:0] rd_out_off;
  logic [7:0] rd_in_off;
  logic [7:0] rd_dat;

  assign rd_out_off = port_id - OUT_BASE;
  assign rd_in_off  = port_id - IN_BASE;

  // Ranges are disjoint, so at most one branch matches.
  always_comb begin
    rd_dat = 8'h00;
    for (int i = 0; i < N_OUT; i++) begin
      if (rd_out_off == 8'(i)) begin
        rd_dat = out_q[i];
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (rd_in_off == 8'(i)) begin
        rd_dat = in_regs[8*i +: 8];
      end
    end
    if (port_id == IRQ_STAT_ADDR) begin
      rd_dat = 8'(pending);
    end
    if (port_id == IRQ_MASK_ADDR) begin
      rd_dat = 8'(mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_port <= 8'h00;
    end else begin
      in_port <= rd_dat;
    end
  end

endmodule

// File: tb/tb_game_io_bridge.sv
// Purpose : self-checking bench for game_io_bridge: directed literal checks plus random traffic vs a model.
// Latency : n/a.
// Backpr. : n/a.
module tb_game_io_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   port_id;
  logic [7:0]   out_port;
  logic         write_strobe;
  logic         k_write_strobe;
  logic         read_strobe;
  logic         interrupt_ack;
  logic [63:0]  in_regs;
  logic [3:0]   irq_src;
  logic [7:0]   in_port;
  logic         interrupt;
  logic [63:0]  out_regs;
  logic [7:0]   k_in_port;
  logic         k_interrupt;
  logic [127:0] k_out_regs;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  game_io_bridge dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
    .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .in_regs(in_regs), .irq_src(irq_src), .out_regs(out_regs)
  );

  // Second instance with OUT_BASE = 0 and 16 outputs, for the OUTPUTK addressing case.
  game_io_bridge #(.N_OUT(16), .OUT_BASE(8'h00)) dut_k (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
    .in_port(k_in_port), .interrupt(k_interrupt), .interrupt_ack(interrupt_ack),
    .in_regs(in_regs), .irq_src(irq_src), .out_regs(k_out_regs)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (default map: out 02..09, in 20..27, stat 30, mask 31) ----------------
  logic [7:0] m_out [8];
  logic [3:0] m_pend, m_mask, m_prev;
  logic       m_int;
  logic [7:0] m_inp;
  logic [7:0] m_rd;
  logic [3:0] m_clr, m_newp;
  logic       m_nint;
  int         m_eff;

  function automatic logic [7:0] m_read(input logic [7:0] p);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (int'(p) == 2 + i)  r = m_out[i];
      if (int'(p) == 32 + i) r = in_regs[8*i +: 8];
    end
    if (p == 8'h30) r = {4'h0, m_pend};
    if (p == 8'h31) r = {4'h0, m_mask};
    return r;
  endfunction

  function automatic logic [63:0] m_out_flat();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_out[i];
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_out[i] = 8'h00;
      m_pend = 4'h0; m_mask = 4'h0; m_prev = 4'h0; m_int = 1'b0; m_inp = 8'h00;
    end else begin
      m_rd   = m_read(port_id);
      m_nint = interrupt_ack ? 1'b0 : |(m_pend & m_mask);
      m_clr  = (write_strobe && port_id == 8'h30) ? out_port[3:0] : 4'h0;
      m_newp = (m_pend & ~m_clr) | (irq_src & ~m_prev);
      if (write_strobe) begin
        for (int i = 0; i < 8; i++) if (int'(port_id) == 2 + i) m_out[i] = out_port;
        if (port_id == 8'h31) m_mask = out_port[3:0];
      end else if (k_write_strobe) begin
        m_eff = int'(port_id[3:0]);  // OUT_BASE[7:4] = 0
        for (int i = 0; i < 8; i++) if (m_eff == 2 + i) m_out[i] = out_port;
      end
      m_inp  = m_rd;
      m_int  = m_nint;
      m_pend = m_newp;
      m_prev = irq_src;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("model out_regs",  128'(out_regs),  128'(m_out_flat()));
      chk("model in_port",   128'(in_port),   128'(m_inp));
      chk("model interrupt", 128'(interrupt), 128'(m_int));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic wrk(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; k_write_strobe = 1'b1;
    tick();
    k_write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] p);
    port_id = p;
    tick();
  endtask

  initial begin
    reset = 1'b1; port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0;
    k_write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    in_regs = 64'h0; irq_src = 4'h0;
    repeat (3) tick();
    chk("reset out_regs",  128'(out_regs),  128'h0);
    chk("reset in_port",   128'(in_port),   128'h0);
    chk("reset interrupt", 128'(interrupt), 128'h0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Plain writes and readback
    wr(8'h03, 8'hA5);
    chk("write 03 -> reg1", 128'(out_regs[15:8]), 128'hA5);
    rd(8'h03);
    chk("readback 03", 128'(in_port), 128'hA5);
    wr(8'hFF, 8'h55);
    chk("unmapped write FF", 128'(out_regs), 128'h0000_0000_0000_A500);

    // OUTPUTK: effective address {OUT_BASE[7:4], 9}
    wrk(8'hF9, 8'h3C);
    chk("outputk base00 reg9", 128'(k_out_regs[79:72]), 128'h3C);
    chk("outputk base02 reg7", 128'(out_regs[63:56]),   128'h3C);

    // Input reads
    in_regs[31:24] = 8'h77;
    rd(8'h23);
    chk("read in ch3", 128'(in_port), 128'h77);
    rd(8'h40);
    chk("read unmapped 40", 128'(in_port), 128'h00);

    // Interrupt handshake
    wr(8'h31, 8'h01);
    irq_src[0] = 1'b1;
    tick();
    chk("irq edge+1 low", 128'(interrupt), 128'h0);
    tick();
    chk("irq edge+2 high", 128'(interrupt), 128'h1);
    irq_src[0] = 1'b0;
    interrupt_ack = 1'b1;
    tick();
    chk("ack m+1 low", 128'(interrupt), 128'h0);
    interrupt_ack = 1'b0;
    tick();
    chk("ack m+2 high", 128'(interrupt), 128'h1);
    wr(8'h30, 8'h01);
    tick();
    chk("w1c int low", 128'(interrupt), 128'h0);
    tick();
    chk("w1c int stays low", 128'(interrupt), 128'h0);
    rd(8'h30);
    chk("pending clear", 128'(in_port), 128'h00);

    // Set and clear of bit 1 in the same cycle: set wins
    irq_src[1] = 1'b1;
    port_id = 8'h30; out_port = 8'h02; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    rd(8'h30);
    chk("set beats clear", 128'(in_port), 128'h02);
    irq_src[1] = 1'b0;
    wr(8'h30, 8'h02);

    // Ack coincident with a new edge
    irq_src[0] = 1'b1; interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("ack+edge low", 128'(interrupt), 128'h0);
    tick();
    chk("ack+edge reassert", 128'(interrupt), 128'h1);
    irq_src[0] = 1'b0;
    wr(8'h30, 8'h01);
    tick();

    // Masked-off pending, then unmask
    wr(8'h31, 8'h00);
    irq_src[1] = 1'b1;
    repeat (3) tick();
    chk("masked no irq", 128'(interrupt), 128'h0);
    rd(8'h30);
    chk("masked pending", 128'(in_port), 128'h02);
    wr(8'h31, 8'h02);
    chk("unmask cycle low", 128'(interrupt), 128'h0);
    tick();
    chk("unmask +1 high", 128'(interrupt), 128'h1);
    irq_src[1] = 1'b0;

    // Asynchronous reset mid-run
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async rst out_regs",  128'(out_regs),  128'h0);
    chk("async rst in_port",   128'(in_port),   128'h0);
    chk("async rst interrupt", 128'(interrupt), 128'h0);
    tick();
    tick();
    reset = 1'b0;
    rd(8'h30);
    chk("post reset pending", 128'(in_port), 128'h00);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: port_id = 8'($urandom);
        4:          port_id = 8'h30;
        5:          port_id = 8'h31;
        6, 7:       port_id = 8'($urandom_range(2, 9));
        8:          port_id = 8'($urandom_range(32, 39));
        default:    port_id = {4'hF, 4'($urandom)};
      endcase
      out_port = 8'($urandom);
      r = $urandom_range(0, 9);
      write_strobe   = (r <= 2) || (r == 4);
      k_write_strobe = (r == 3) || (r == 4);
      read_strobe    = 1'($urandom);
      interrupt_ack  = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) irq_src[b] = ~irq_src[b];
      end
      if ($urandom_range(0, 15) == 0) in_regs = {$urandom, $urandom};
      reset = (c >= 1500 && c < 1502);
      tick();
    end
    write_strobe = 1'b0; k_write_strobe = 1'b0; reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_io_bridge.md
# game_io_bridge

Parametrised PicoBlaze (KCPSM6) port-mapped I/O bridge connecting the game processor to its peripherals: bot registers, seven-segment digits, LEDs, buttons/switches and motor control. It provides a bank of N_OUT writable output registers, N_IN readable input channels and an N_IRQ-source maskable interrupt controller with the KCPSM6 interrupt/ack handshake. Unmapped accesses have no side effects. All address bases are parameters, so new peripherals are added without RTL edits.

## Interface
- N_OUT, 8: number of 8-bit output registers (1..16).
- N_IN, 8: number of 8-bit input channels (1..16).
- N_IRQ, 4: number of interrupt sources (1..8).
- OUT_BASE, 8'h02: port_id of output register 0. OUT_BASE[3:0] must be 0 whenever OUTPUTK access is used.
- IN_BASE, 8'h20: port_id of input channel 0.
- IRQ_STAT_ADDR, 8'h30: pending register. Read returns pending bits; writing 1 to a bit clears it.
- IRQ_MASK_ADDR, 8'h31: mask register, read/write.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- port_id  in  8  KCPSM6 port address.
- out_port  in  8  KCPSM6 write data.
- write_strobe  in  1  OUTPUT strobe.
- k_write_strobe  in  1  OUTPUTK strobe.
- read_strobe  in  1  INPUT strobe. It has no side effects and is kept for monitoring.
- in_port  out  8  registered read data.
- interrupt  out  1  interrupt request to KCPSM6.
- interrupt_ack  in  1  KCPSM6 interrupt acknowledge.
- in_regs  in  N_IN*8  input channels; channel i is bits [8i+7:8i].
- irq_src  in  N_IRQ  event sources, synchronous to clk.
- out_regs  out  N_OUT*8  output registers; register i is bits [8i+7:8i].

## Operation
**Address ranges**
- Address ranges must not overlap. Overlap is a parameter error and is checked at elaboration.

**Writes (write_strobe = 1)**
- If port_id is in [OUT_BASE, OUT_BASE+N_OUT), out_regs[port_id-OUT_BASE] <= out_port.
- A write to IRQ_MASK_ADDR loads the mask.
- A write to IRQ_STAT_ADDR clears the pending bits where out_port = 1.
- Writes to any other address are ignored.

**OUTPUTK writes (k_write_strobe = 1)**
- The effective address is {OUT_BASE[7:4], port_id[3:0]}.
- If the effective address falls in the output range, that register is written; otherwise the write is ignored.
- write_strobe and k_write_strobe are never both high (KCPSM6 guarantee). If they are, write_strobe takes priority.

**Reads**
- in_port is registered every cycle from the current port_id, independent of read_strobe.
- Read map:
  - input range: the corresponding in_regs channel;
  - output range: readback of out_regs;
  - IRQ_STAT_ADDR: {pending, zero-padded};
  - IRQ_MASK_ADDR: {mask, zero-padded};
  - any other address: 8'h00.

**Interrupt controller (sub-module irq_ctrl)**
- Edge detection: src_q <= irq_src each cycle. rise = irq_src & ~src_q.
- Pending update: pending <= (pending & ~clr) | rise. If a set and a clear hit the same bit in the same cycle, the set wins.
- Interrupt output, evaluated every cycle:
  - if interrupt_ack = 1, interrupt <= 0;
  - otherwise interrupt <= |(pending & mask).
- interrupt_ack has priority over a new request in the same cycle. The request is re-evaluated on the following cycle.
- A source held high generates exactly one pending event.
- Clearing the mask does not clear pending; unmasking a pending bit raises interrupt.

**Reset**
- All out_regs = 8'h00.
- in_port = 8'h00.
- pending = 0, mask = 0.
- src_q = 0. As a result, a source that is high when reset is released registers an edge on the first clock.
- interrupt = 0.
- Reset during an ISR drops interrupt immediately. No pending state survives.

## Timing
- Write: the register updates on the clk edge where the strobe is high. The new value is visible on out_regs and in readback one cycle later.
- Read latency: in_port is valid 1 cycle after port_id is stable. This meets the KCPSM6 2-cycle INPUT window.
- irq_src rising at edge n:
  - pending is set at edge n+1;
  - interrupt is high at edge n+2 (if masked on).
- interrupt_ack at edge m drives interrupt low at m+1. interrupt re-asserts at m+2 if a masked pending bit remains. KCPSM6 ignores it until RETURNI ENABLE.
- The W1C clear at edge k is reflected in interrupt at k+2.

## Structure
- Package game_io_pkg holds:
  - default address constants (OUT_BASE, IN_BASE, IRQ_STAT_ADDR, IRQ_MASK_ADDR);
  - named output indices (LED=0, DIG3..DIG0=1..4, DP=5, MOTCTL=7);
  - named input indices (BTNS, SW, LOCX, LOCY, BOTINFO, SENSORS, LMDIST, RMDIST);
  - IRQ source indices (UPD_SYSREGS=0, MSEC_TICK=1).
- Sub-module irq_ctrl is parametrised by N_IRQ. It holds src_q, pending, mask and interrupt, and has clear/mask-write/ack inputs.
- Top-level game_io_bridge contains the decode logic, the output bank and the read mux.

## Test plan
- Reset: assert reset mid-run → all out_regs = 0, in_port = 0, interrupt = 0 asynchronously; reading 8'h30 returns 8'h00.
- Writes:
  - write_strobe, port 8'h03, data 8'hA5 → out_regs[1] = 8'hA5 on the next cycle; reading 8'h03 returns 8'hA5;
  - port 8'hFF → no register changes.
- OUTPUTK: k_write_strobe, port_id 8'hF9, data 8'h3C, OUT_BASE = 8'h00 → out_regs[9] = 8'h3C.
- Reads: in_regs channel 3 = 8'h77, port_id 8'h23 → in_port = 8'h77 one cycle later; unmapped port 8'h40 → 8'h00.
- Interrupt handshake: mask = 8'h01, pulse irq_src[0] → interrupt high 2 cycles later; ack → interrupt low at m+1 and high again at m+2; write 8'h01 to 8'h30 → interrupt stays low.
- Simultaneous events:
  - irq_src[1] rises in the same cycle as a W1C of bit 1 → pending bit 1 remains set;
  - ack in the same cycle as a new edge → interrupt low for one cycle, then reasserted;
  - mask = 0 with bit pending → no interrupt; then set mask = 8'h02 → interrupt is high 1 cycle after the mask-write cycle.
